// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one active-low column per scan tick,
// synchronizes the active-low row lines, debounces presses and releases,
// and reports each accepted key once as {row, col} with a one-clk pulse.
module keypad_scanner #(
  parameter int unsigned DEBOUNCE_SCANS = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ENA,
  input  logic [3:0] rows_in,
  output logic [3:0] col_drive,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] DS_L = 4'(DEBOUNCE_SCANS);

  state_t     state_q, state_d;
  logic [3:0] rows_meta_q, rows_s_q;
  logic [1:0] col_idx_q, col_idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cand_q, cand_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       cand_row_low;
  logic [3:0] cnt_inc;

  // Saturating increment so a long stable input never wraps the counter.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  // Lowest-numbered active-low row wins when several rows are pulled low.
  function automatic logic [1:0] lowest_row(input logic [3:0] rows);
    if (!rows[0])      return 2'd0;
    else if (!rows[1]) return 2'd1;
    else if (!rows[2]) return 2'd2;
    else               return 2'd3;
  endfunction

  assign cand_row_low = ~rows_s_q[cand_q[3:2]];
  assign cnt_inc      = sat_inc(cnt_q);

  // Next-state logic: every scan/debounce action is gated by the ENA tick.
  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    cnt_d       = cnt_q;
    cand_d      = cand_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    if (ENA) begin
      unique case (state_q)
        SCAN: begin
          if (rows_s_q == 4'hF) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            cand_d = {lowest_row(rows_s_q), col_idx_q};
            cnt_d  = 4'd1;
            if (DS_L == 4'd1) begin
              state_d     = HELD;
              key_code_d  = {lowest_row(rows_s_q), col_idx_q};
              key_valid_d = 1'b1;
            end else begin
              state_d = DEBOUNCE;
            end
          end
        end
        DEBOUNCE: begin
          if (cand_row_low) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DS_L) begin
              state_d     = HELD;
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
            end
          end else begin
            cnt_d     = 4'd0;
            state_d   = SCAN;
            col_idx_d = col_idx_q + 2'd1;
          end
        end
        HELD: begin
          // Only the candidate row matters; other rows in this column are ignored.
          if (!cand_row_low) begin
            cnt_d = 4'd1;
            if (DS_L == 4'd1) begin
              state_d   = SCAN;
              col_idx_d = col_idx_q + 2'd1;
              cnt_d     = 4'd0;
            end else begin
              state_d = RELEASE;
            end
          end
        end
        RELEASE: begin
          if (!cand_row_low) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DS_L) begin
              state_d   = SCAN;
              col_idx_d = col_idx_q + 2'd1;
              cnt_d     = 4'd0;
            end
          end else begin
            // Release bounce: key is still down, no new report.
            state_d = HELD;
            cnt_d   = 4'd0;
          end
        end
        default: state_d = SCAN;
      endcase
    end
  end

  // State, synchronizer and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= SCAN;
      rows_meta_q <= 4'hF;
      rows_s_q    <= 4'hF;
      col_idx_q   <= 2'd0;
      cnt_q       <= 4'd0;
      cand_q      <= 4'd0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
    end else begin
      rows_meta_q <= rows_in;
      rows_s_q    <= rows_meta_q;
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      cnt_q       <= cnt_d;
      cand_q      <= cand_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign col_drive = ~(4'b0001 << col_idx_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign key_held  = (state_q == HELD) || (state_q == RELEASE);

endmodule
